// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO write arbiter.
//   - FSM state encoding (ARB / WRITE)
//   - clog2 helper used to size the requester index
//   - tag width: IDW when FIFO_ARB_TAG_EN is defined, otherwise 0
package fifo_arb_pkg;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

`ifdef FIFO_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Width of the index field prepended to each FIFO word.
  function automatic int tag_w(input int idw);
    return TAG_EN ? idw : 0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
//   req    [N-1:0]   request vector
//   rr_ptr [IDW-1:0] highest-priority position this round
//   valid            any request set
//   idx    [IDW-1:0] first set req bit at or after rr_ptr, wrapping mod N
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] rr_ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest hit is the last
  // assignment and therefore wins.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among N
// producers. One grant per two cycles at most (ARB -> WRITE -> ARB).
//   clk, reset_n   clock, async active-low reset
//   req [N-1:0]    producer requests
//   data [N*B-1:0] producer words, producer i at [i*B +: B]
//   gnt [N-1:0]    registered one-hot grant, high in the write cycle
//   fifo_full      FIFO full flag, sampled only in ARB
//   fifo_wr        registered FIFO write enable
//   fifo_w_data    registered FIFO word; {index, data} when FIFO_ARB_TAG_EN
//                  is defined, data only otherwise
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int B   = 8,
  localparam int IDW = clog2(N),
  localparam int FW  = B + tag_w(IDW)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*B-1:0] data,
  output logic [N-1:0]   gnt,
  input  logic           fifo_full,
  output logic           fifo_wr,
  output logic [FW-1:0]  fifo_w_data
);

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] win_q, win_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           fifo_wr_q, fifo_wr_d;
  logic [FW-1:0]  fifo_w_data_q, fifo_w_data_d;

  logic           pick_valid;
  logic [IDW-1:0] pick_idx;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // Output registers are loaded on the ARB->WRITE edge, so WRITE sees the
  // latched word and ARB keeps the last word while wr/gnt stay low.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    win_d         = win_q;
    gnt_d         = '0;
    fifo_wr_d     = 1'b0;
    fifo_w_data_d = fifo_w_data_q;
    case (state_q)
      ST_ARB: begin
        // Sole writer: full cannot rise before the WRITE cycle.
        if (pick_valid && !fifo_full) begin
          win_d     = pick_idx;
          gnt_d     = N'(1) << pick_idx;
          fifo_wr_d = 1'b1;
`ifdef FIFO_ARB_TAG_EN
          fifo_w_data_d = {pick_idx, data[int'(pick_idx)*B +: B]};
`else
          fifo_w_data_d = data[int'(pick_idx)*B +: B];
`endif
          state_d = ST_WRITE;
        end
      end
      default: begin
        rr_ptr_d = (win_q == IDW'(N - 1)) ? '0 : win_q + IDW'(1);
        state_d  = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_ARB;
      rr_ptr_q      <= '0;
      win_q         <= '0;
      gnt_q         <= '0;
      fifo_wr_q     <= 1'b0;
      fifo_w_data_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      win_q         <= win_d;
      gnt_q         <= gnt_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_w_data_q <= fifo_w_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign fifo_wr     = fifo_wr_q;
  assign fifo_w_data = fifo_w_data_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter with N=4, B=8 (tag field present when
// FIFO_ARB_TAG_EN is defined).
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int B = 8;
`ifdef FIFO_ARB_TAG_EN
  localparam int FW = B + 2;
`else
  localparam int FW = B;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*B-1:0] data = '0;
  logic           fifo_full = 1'b0;
  logic [N-1:0]   gnt;
  logic           fifo_wr;
  logic [FW-1:0]  fifo_w_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [FW-1:0] wq[$];

  fifo_wr_arbiter #(.N(N), .B(B)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .data        (data),
    .gnt         (gnt),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_w_data (fifo_w_data)
  );

  always #5 clk = ~clk;

  // FIFO model: capture every word written at a rising edge.
  always @(posedge clk) if (fifo_wr) wq.push_back(fifo_w_data);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [FW-1:0] word(input int idx, input logic [B-1:0] d);
    logic [1:0] ix;
    ix = idx[1:0];
`ifdef FIFO_ARB_TAG_EN
    return {ix, d};
`else
    return FW'(d) | FW'(ix & 2'b00);
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n   = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req     = 4'b1111;
    data    = {8'd3, 8'd2, 8'd1, 8'd0};
    tick();
    n_tests++;
    if ({gnt, fifo_wr, fifo_w_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: gnt=%b wr=%b wdata=%h, want 0/0/0", gnt, fifo_wr, fifo_w_data);
    end
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (gnt !== 4'b0000 || fifo_wr !== 1'b0 || fifo_w_data !== '0) begin
      n_fail++;
      $display("FAIL reset_release: gnt=%b wr=%b wdata=%h, want 0/0/0", gnt, fifo_wr, fifo_w_data);
    end
    tick();
    n_tests++;
    if (gnt !== 4'b0001 || fifo_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: gnt=%b wr=%b, want 0001/1", gnt, fifo_wr);
    end
    req = '0;
    tick();
  endtask

  task automatic test_single;
    do_reset();
    data[2*B +: B] = 8'hA5;
    req = 4'b0100;
    wq.delete();
    tick();
    n_tests++;
    if (gnt !== 4'b0100 || fifo_wr !== 1'b1 || fifo_w_data !== word(2, 8'hA5)) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b wr=%b wdata=%h, want 0100/1/%h",
               gnt, fifo_wr, fifo_w_data, word(2, 8'hA5));
    end
    req = '0;
    tick();
    n_tests++;
    if (gnt !== 4'b0000 || fifo_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: gnt=%b wr=%b, want 0000/0", gnt, fifo_wr);
    end
    n_tests++;
    if (wq.size() != 1 || wq[0] !== word(2, 8'hA5)) begin
      n_fail++;
      $display("FAIL single_fifo: size=%0d head=%h, want 1/%h",
               wq.size(), (wq.size() > 0) ? wq[0] : '0, word(2, 8'hA5));
    end
  endtask

  task automatic test_rotation;
    logic [N-1:0] eg;
    do_reset();
    data = {8'd3, 8'd2, 8'd1, 8'd0};
    req  = 4'b1111;
    wq.delete();
    for (int c = 0; c < 10; c++) begin
      tick();
      eg = (c % 2 == 0) ? 4'(1 << ((c / 2) % 4)) : 4'b0000;
      n_tests++;
      if (gnt !== eg || fifo_wr !== (eg != 0)) begin
        n_fail++;
        $display("FAIL rotation_c%0d: gnt=%b wr=%b, want %b", c, gnt, fifo_wr, eg);
      end
    end
    req = '0;
    tick();
    n_tests++;
    if (wq.size() != 5) begin
      n_fail++;
      $display("FAIL rotation_count: got %0d writes, want 5", wq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (wq[i] !== word(i % 4, 8'(i % 4))) begin
          n_fail++;
          $display("FAIL rotation_fifo%0d: got %h, want %h", i, wq[i], word(i % 4, 8'(i % 4)));
        end
      end
    end
  endtask

  task automatic test_full_stall;
    do_reset();
    fifo_full = 1'b1;
    data[1*B +: B] = 8'h77;
    req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if (gnt !== 4'b0000 || fifo_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL full_stall_c%0d: gnt=%b wr=%b, want 0000/0", c, gnt, fifo_wr);
      end
    end
    fifo_full = 1'b0;
    tick();
    n_tests++;
    if (gnt !== 4'b0010 || fifo_wr !== 1'b1 || fifo_w_data !== word(1, 8'h77)) begin
      n_fail++;
      $display("FAIL full_release: gnt=%b wr=%b wdata=%h, want 0010/1/%h",
               gnt, fifo_wr, fifo_w_data, word(1, 8'h77));
    end
    req = '0;
    tick();
  endtask

  task automatic test_tag;
    logic [FW-1:0] exp_w;
`ifdef FIFO_ARB_TAG_EN
    exp_w = 10'h33C;
`else
    exp_w = 8'h3C;
`endif
    do_reset();
    data[3*B +: B] = 8'h3C;
    req = 4'b1000;
    tick();
    n_tests++;
    if (fifo_w_data !== exp_w || gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL tag_word: wdata=%h gnt=%b, want %h/1000", fifo_w_data, gnt, exp_w);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_write;
    int n;
    do_reset();
    data[0 +: B] = 8'h5A;
    req = 4'b0001;
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL midwr_grant: gnt=%b, want 0001", gnt);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (gnt !== 4'b0000 || fifo_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL midwr_async_clear: gnt=%b wr=%b, want 0000/0", gnt, fifo_wr);
    end
    n = wq.size();
    tick();
    n_tests++;
    if (wq.size() != n) begin
      n_fail++;
      $display("FAIL midwr_no_write: writes=%0d, want %0d", wq.size(), n);
    end
    reset_n = 1'b1;
    tick();
    n_tests++;
    if (gnt !== 4'b0001 || fifo_w_data !== word(0, 8'h5A)) begin
      n_fail++;
      $display("FAIL midwr_regrant: gnt=%b wdata=%h, want 0001/%h", gnt, fifo_w_data, word(0, 8'h5A));
    end
    req = '0;
    tick();
  endtask

  // Reference: a grant cycle is always followed by an idle cycle that
  // advances the pointer past the winner; otherwise, if not full, the first
  // requester at or after the pointer wins.
  task automatic test_random;
    int ptr, win;
    bit busy;
    logic [N-1:0]  eg;
    logic          ewr;
    logic [FW-1:0] ew;
    do_reset();
    ptr  = 0;
    win  = 0;
    busy = 1'b0;
    ew   = '0;
    for (int c = 0; c < 400; c++) begin
      req       = 4'($urandom_range(0, 15));
      data      = $urandom();
      fifo_full = ($urandom_range(0, 3) == 0);
      eg  = '0;
      ewr = 1'b0;
      if (busy) begin
        ptr  = (win + 1) % N;
        busy = 1'b0;
      end else if (!fifo_full && req != 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(ptr + k) % N]) win = (ptr + k) % N;
        eg   = 4'(1 << win);
        ewr  = 1'b1;
        ew   = word(win, data[win*B +: B]);
        busy = 1'b1;
      end
      tick();
      n_tests++;
      if (gnt !== eg || fifo_wr !== ewr || fifo_w_data !== ew) begin
        n_fail++;
        $display("FAIL random_c%0d: gnt=%b wr=%b wdata=%h, want %b/%b/%h",
                 c, gnt, fifo_wr, fifo_w_data, eg, ewr, ew);
      end
    end
    req       = '0;
    fifo_full = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_full_stall();
    test_tag();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
